muldiv_hilo_unit: RTL and testbench

//  EX-stage producer of HI/LO writes: executes MULT/MULTU/DIV/DIVU (multi-cycle) and MTHI/MTLO
//  (single-cycle), driving the hi/lo write-enable/data bus consumed by the HI/LO register/forwarding

---
 rtl/muldiv_hilo_unit.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
//   EX-stage HI/LO write producer. Runs MULT/MULTU (MUL_CYCLES cycles) and
//   DIV/DIVU (radix-2 restoring, DW cycles) as multi-cycle operations. The
//   single-cycle MTHI/MTLO pass straight through. The pipeline is held with
//   stallreq_o while an operation is in flight. The finished result is shown
//   with both write enables until EX is released (hold_i low).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush_i         abort any operation; suppress every write this cycle
//   hold_i          downstream stall; keeps the DONE result on the bus
//   valid_i, op_i   instruction in EX (0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,
//                   5 MTHI,6 MTLO)
//   src_a_i/b_i     rs / rt operands
//   stallreq_o      hold EX while busy
//   hi_we_o/lo_we_o HI/LO write enables
//   hi_o/lo_o       HI/LO write data
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | accept a new op; MTHI/MTLO are written from here combinationally
// S_MUL  | product of the latched operands registered each cycle
// S_DIV  | one quotient bit per cycle over the magnitudes
// S_DONE | result on hi_o/lo_o with both write enables; waits out hold_i
module muldiv_hilo_unit #(
  parameter int DW         = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          hold_i,
  input  logic          valid_i,
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] src_a_i,
  input  logic [DW-1:0] src_b_i,
  output logic          stallreq_o,
  output logic          hi_we_o,
  output logic          lo_we_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CMAX = (DW > MUL_CYCLES) ? DW : MUL_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // a_q: multiplicand, or the dividend that is shifted out while quotient bits shift in
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          sgn_q, sgn_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  // Signed multiply via sign extension to 2*DW; the low 2*DW bits of the
  // unsigned product equal the two's-complement signed product.
  logic [2*DW-1:0] mul_ea, mul_eb, mul_p;
  assign mul_ea = {{DW{sgn_q & a_q[DW-1]}}, a_q};
  assign mul_eb = {{DW{sgn_q & b_q[DW-1]}}, b_q};
  assign mul_p  = mul_ea * mul_eb;

  // One restoring step. Partial remainder stays below the divisor, so the
  // DW+1 bit difference has its top bit set exactly when the trial goes negative.
  logic [DW:0]   rem_sh, rem_diff;
  logic          q_bit;
  logic [DW-1:0] rem_nx, quo_nx;
  assign rem_sh   = {rem_q, a_q[DW-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign q_bit    = ~rem_diff[DW];
  assign rem_nx   = q_bit ? rem_diff[DW-1:0] : rem_sh[DW-1:0];
  assign quo_nx   = {a_q[DW-2:0], q_bit};

  logic          div_signed;
  logic [DW-1:0] abs_a, abs_b;
  assign div_signed = (op_i == OP_DIV);
  assign abs_a = (div_signed && src_a_i[DW-1]) ? -src_a_i : src_a_i;
  assign abs_b = (div_signed && src_b_i[DW-1]) ? -src_b_i : src_b_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    sgn_d      = sgn_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stallreq_o = 1'b0;
    hi_we_o    = 1'b0;
    lo_we_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;

    if (rst || flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            case (op_i)
              OP_MULT, OP_MULTU: begin
                stallreq_o = 1'b1;
                a_d        = src_a_i;
                b_d        = src_b_i;
                sgn_d      = (op_i == OP_MULT);
                cnt_d      = '0;
                state_d    = S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                stallreq_o = 1'b1;
                a_d        = abs_a;
                b_d        = abs_b;
                negq_d     = div_signed & (src_a_i[DW-1] ^ src_b_i[DW-1]);
                negr_d     = div_signed & src_a_i[DW-1];
                rem_d      = '0;
                cnt_d      = '0;
                state_d    = S_DIV;
              end
              OP_MTHI: begin
                hi_we_o = 1'b1;
                hi_o    = src_a_i;
              end
              OP_MTLO: begin
                lo_we_o = 1'b1;
                lo_o    = src_a_i;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          stallreq_o   = 1'b1;
          {hi_d, lo_d} = mul_p;
          cnt_d        = cnt_q + CW'(1);
          if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = S_DONE;
        end
        S_DIV: begin
          stallreq_o = 1'b1;
          a_d        = quo_nx;
          rem_d      = rem_nx;
          cnt_d      = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            lo_d    = negq_q ? -quo_nx : quo_nx;
            hi_d    = negr_q ? -rem_nx : rem_nx;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          hi_we_o = 1'b1;
          lo_we_o = 1'b1;
          hi_o    = hi_q;
          lo_o    = lo_q;
          if (!hold_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
module tb_muldiv_hilo_unit;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        rst, flush, hold, valid;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        stallreq, hi_we, lo_we;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  muldiv_hilo_unit #(.DW(32), .MUL_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .hold_i(hold), .valid_i(valid),
    .op_i(op), .src_a_i(a), .src_b_i(b), .stallreq_o(stallreq),
    .hi_we_o(hi_we), .lo_we_o(lo_we), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: architectural HI/LO results from plain integer arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    longint      sx, sy, q, r;
    logic [31:0] qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = '0; l = '0;
    case (o)
      OP_MULT:  begin p = 64'(sx * sy); h = p[63:32]; l = p[31:0]; end
      OP_MULTU: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
      OP_DIVU: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin h = x % y; l = x / y; end
      end
      OP_DIV: begin
        if (y == 0) begin
          qq = 32'hFFFF_FFFF;
          rr = x[31] ? -x : x;
          if (x[31] ^ y[31]) qq = -qq;
          if (x[31]) rr = -rr;
          h = rr; l = qq;
        end else begin
          q = sx / sy;
          r = sx % sy;
          h = r[31:0]; l = q[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Issues one multi-cycle op at cycle T (from IDLE), scrambles the sources
  // while busy, and checks stall, latency, result and the return to idle.
  task automatic exec_op(input string name, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                         input int hold_cycles);
    logic [31:0] gh, gl;
    int lat, exp_lat;
    bit got, stall_ok;
    exp_lat = (o == OP_DIV || o == OP_DIVU) ? 33 : 3;
    gh = '0; gl = '0;
    @(posedge clk); #1;
    valid = 1'b1; op = o; a = x; b = y; hold = (hold_cycles > 0);
    @(negedge clk);
    stall_ok = (stallreq === 1'b1 && hi_we === 1'b0 && lo_we === 1'b0);
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
      @(negedge clk);
      if (hi_we === 1'b1 || lo_we === 1'b1) begin
        got = 1'b1; lat = i; gh = hi; gl = lo;
      end else if (stallreq !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s timeout: no write enable within 60 cycles", name);
      @(posedge clk); #1;
      valid = 1'b0; op = OP_NONE; hold = 1'b0;
      return;
    end
    chk({name, " stall"}, 64'(stall_ok), 64'd1);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " we/stall"}, {61'b0, hi_we, lo_we, stallreq}, 64'b110);
    chk({name, " hi"}, 64'(gh), 64'(eh));
    chk({name, " lo"}, 64'(gl), 64'(el));
    for (int k = 1; k <= hold_cycles; k++) begin
      @(posedge clk); #1;
      if (k == hold_cycles) hold = 1'b0;
      @(negedge clk);
      chk({name, " held ctl"}, {61'b0, hi_we, lo_we, stallreq}, 64'b110);
      chk({name, " held data"}, {hi, lo}, {eh, el});
    end
    @(posedge clk); #1;
    valid = 1'b0; op = OP_NONE;
    @(negedge clk);
    chk({name, " idle after"}, {61'b0, stallreq, hi_we, lo_we}, 64'b0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, eh, el;
    bit          we_seen;

    vecs[0]  = '{"divu 100/7",      OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14};
    vecs[1]  = '{"div -7/2",        OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
    vecs[2]  = '{"div 7/-2",        OP_DIV,   32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD};
    vecs[3]  = '{"mult -1*2",       OP_MULT,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[4]  = '{"multu ffffffff*2",OP_MULTU, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'hFFFF_FFFE};
    vecs[5]  = '{"div 9/0",         OP_DIV,   32'd9,          32'd0,          32'd9,          32'hFFFF_FFFF};
    vecs[6]  = '{"divu 9/0",        OP_DIVU,  32'd9,          32'd0,          32'd9,          32'hFFFF_FFFF};
    vecs[7]  = '{"div intmin/-1",   OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[8]  = '{"mult intmin^2",   OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'd0};
    vecs[9]  = '{"divu max/1",      OP_DIVU,  32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF};
    vecs[10] = '{"div -9/0",        OP_DIV,   32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFF7,  32'd1};
    vecs[11] = '{"divu max/max",    OP_DIVU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1};

    rst = 1'b1; flush = 1'b0; hold = 1'b0; valid = 1'b0; op = OP_NONE; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ctl", {61'b0, stallreq, hi_we, lo_we}, 64'b0);
    chk("reset data", {hi, lo}, 64'b0);

    foreach (vecs[i])
      exec_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0);

    // MTHI then MTLO back to back, then MTHI under flush.
    @(posedge clk); #1;
    valid = 1'b1; op = OP_MTHI; a = 32'h1234;
    @(negedge clk);
    chk("mthi ctl", {61'b0, stallreq, hi_we, lo_we}, 64'b010);
    chk("mthi data", 64'(hi), 64'h1234);
    @(posedge clk); #1;
    op = OP_MTLO; a = 32'h5678;
    @(negedge clk);
    chk("mtlo ctl", {61'b0, stallreq, hi_we, lo_we}, 64'b001);
    chk("mtlo data", 64'(lo), 64'h5678);
    @(posedge clk); #1;
    op = OP_MTHI; flush = 1'b1;
    @(negedge clk);
    chk("mthi flushed ctl", {61'b0, stallreq, hi_we, lo_we}, 64'b0);
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0; op = OP_NONE;

    // Hold in DONE for three cycles.
    exec_op("mult hold", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);

    // Flush at T+10 of a DIV: idle at T+11, never a write.
    @(posedge clk); #1;
    valid = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    we_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 10) flush = 1'b1;
      if (i == 11) begin flush = 1'b0; valid = 1'b0; op = OP_NONE; end
      @(negedge clk);
      if (hi_we === 1'b1 || lo_we === 1'b1) we_seen = 1'b1;
      if (i == 11) chk("flush idle stall", 64'(stallreq), 64'd0);
    end
    chk("flush no write", 64'(we_seen), 64'd0);
    exec_op("multu 3*5 after flush", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 0);

    // Reset in the middle of a DIV.
    @(posedge clk); #1;
    valid = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0; op = OP_NONE;
    @(negedge clk);
    chk("rst mid-op ctl", {61'b0, stallreq, hi_we, lo_we}, 64'b0);
    we_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hi_we === 1'b1 || lo_we === 1'b1 || stallreq === 1'b1) we_seen = 1'b1;
    end
    chk("rst mid-op quiet", 64'(we_seen), 64'd0);

    // Randomized ops against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 20));
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 200));
      model(ro, ra, rb, eh, el);
      exec_op($sformatf("rand%0d op%0d", n, ro), ro, ra, rb, eh, el, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
